// File: rtl/nfu_pkg.sv
// Shared definitions for the NFU-3 piecewise-linear activation stage:
// mode encodings, default widths and default saturation limits.
// Optional feature macro used by this slice: NFU3_COEF_DBUF_EN.
package nfu_pkg;

    localparam int DEF_BIT_WIDTH = 16;
    localparam int DEF_FRAC_BITS = 10;
    localparam int DEF_SEG_BITS  = 4;

    // Encoding 3 is reserved and behaves as bypass.
    typedef enum logic [1:0] {
        MODE_PWL    = 2'd0,
        MODE_RELU   = 2'd1,
        MODE_BYPASS = 2'd2
    } mode_e;

    // Saturation limits for the default data width.
    localparam logic signed [DEF_BIT_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_BIT_WIDTH-1){1'b1}}};
    localparam logic signed [DEF_BIT_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_BIT_WIDTH-1){1'b0}}};

endpackage

// File: rtl/nfu3_pwl_act_if.sv
// Sample, mode and coefficient-table signals of the NFU-3 activation stage.
// Handshake: a sample is taken when i_valid=1 on a rising edge with the
// stage enable high; o_valid marks o_data as a fresh result (no back-pressure,
// the global enable is the only flow control).
// With NFU3_COEF_DBUF_EN defined the bus also carries i_coef_swap.
interface nfu3_pwl_act_if #(
    parameter int BIT_WIDTH = 16,
    parameter int Tn        = 16,
    parameter int SEG_BITS  = 4
);
    logic                     i_valid;
    logic [Tn*BIT_WIDTH-1:0]  i_data;
    logic [1:0]               i_mode;
    logic                     i_coef_wr;
    logic [SEG_BITS-1:0]      i_coef_addr;
    logic [2*BIT_WIDTH-1:0]   i_coef_data;
`ifdef NFU3_COEF_DBUF_EN
    logic                     i_coef_swap;
`endif
    logic                     o_valid;
    logic [Tn*BIT_WIDTH-1:0]  o_data;

`ifdef NFU3_COEF_DBUF_EN
    modport master (output i_valid, i_data, i_mode, i_coef_wr, i_coef_addr,
                    i_coef_data, i_coef_swap, input o_valid, o_data);
    modport slave  (input i_valid, i_data, i_mode, i_coef_wr, i_coef_addr,
                    i_coef_data, i_coef_swap, output o_valid, o_data);
`else
    modport master (output i_valid, i_data, i_mode, i_coef_wr, i_coef_addr,
                    i_coef_data, input o_valid, o_data);
    modport slave  (input i_valid, i_data, i_mode, i_coef_wr, i_coef_addr,
                    i_coef_data, output o_valid, o_data);
`endif
endinterface

// File: rtl/nfu3_pwl_lane.sv
// One lane of the activation datapath: S1 operand capture, S2 multiply,
// S3 shift/add/saturate or ReLU/bypass select. Valid and mode pipelines
// are shared and live in the top; this lane only sees the S2 copies.
module nfu3_pwl_lane
    import nfu_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_vld2,
    input  logic [1:0]           i_mode2,
    input  logic [BIT_WIDTH-1:0] i_x,
    input  logic [BIT_WIDTH-1:0] i_a,
    input  logic [BIT_WIDTH-1:0] i_b,
    output logic [BIT_WIDTH-1:0] o_y
);
    localparam int W  = BIT_WIDTH;
    localparam int PW = 2 * BIT_WIDTH;
    localparam logic signed [PW:0] SAT_HI = {{(W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW:0] SAT_LO = {{(W+2){1'b1}}, {(W-1){1'b0}}};

    logic signed [W-1:0]  r_x1, r_a1, r_b1;
    logic signed [W-1:0]  r_x2, r_b2;
    logic signed [PW-1:0] r_p2;
    logic [W-1:0]         r_y3;

    logic signed [PW-1:0] w_p;
    logic signed [PW:0]   w_pext, w_shift, w_bext, w_sum;
    logic [W-1:0]         w_sat, w_res;

    // Full-precision product; shift is arithmetic so it truncates toward -inf.
    assign w_p     = r_x1 * r_a1;
    assign w_pext  = {r_p2[PW-1], r_p2};
    assign w_shift = w_pext >>> FRAC_BITS;
    assign w_bext  = {{(W+1){r_b2[W-1]}}, r_b2};
    assign w_sum   = w_shift + w_bext;

    // Clamp the wide PWL sum to the signed output range.
    always_comb begin
        w_sat = w_sum[W-1:0];
        if (w_sum > SAT_HI)
            w_sat = SAT_HI[W-1:0];
        else if (w_sum < SAT_LO)
            w_sat = SAT_LO[W-1:0];
    end

    // Per-sample result selection by the mode that travelled with the sample.
    always_comb begin
        w_res = r_x2;
        case (i_mode2)
            MODE_PWL:  w_res = w_sat;
            MODE_RELU: w_res = r_x2[W-1] ? '0 : r_x2;
            default:   w_res = r_x2;
        endcase
    end

    // S1 and S2 operand registers advance together on enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x1 <= '0;
            r_a1 <= '0;
            r_b1 <= '0;
            r_x2 <= '0;
            r_b2 <= '0;
            r_p2 <= '0;
        end else if (i_en) begin
            r_x1 <= i_x;
            r_a1 <= i_a;
            r_b1 <= i_b;
            r_x2 <= r_x1;
            r_b2 <= r_b1;
            r_p2 <= w_p;
        end
    end

    // S3 output register only loads for valid samples; bubbles leave it alone.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_y3 <= '0;
        else if (i_en && i_vld2)
            r_y3 <= w_res;
    end

    assign o_y = r_y3;

endmodule

// File: rtl/nfu3_pwl_act.sv
// NFU-3 activation stage top: coefficient table, shared valid/mode pipeline
// and Tn parallel lanes. Optional macro NFU3_COEF_DBUF_EN adds a shadow
// table bank and i_coef_swap on the bus.
module nfu3_pwl_act
    import nfu_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int Tn        = 16,
    parameter int SEG_BITS  = DEF_SEG_BITS
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_en,
    nfu3_pwl_act_if.slave  bus
);
    localparam int W    = BIT_WIDTH;
    localparam int NSEG = 1 << SEG_BITS;

    logic             r_vld1, r_vld2, r_vld3;
    logic [1:0]       r_mode1, r_mode2;
    logic [Tn*W-1:0]  w_odata;

`ifdef NFU3_COEF_DBUF_EN
    logic [W-1:0] r_tab_a [2][NSEG];
    logic [W-1:0] r_tab_b [2][NSEG];
    logic         r_act;

    // Writes land in the bank that is shadow before any same-edge swap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int s = 0; s < NSEG; s++) begin
                    r_tab_a[b][s] <= '0;
                    r_tab_b[b][s] <= '0;
                end
            r_act <= 1'b0;
        end else begin
            if (bus.i_coef_wr) begin
                r_tab_a[~r_act][bus.i_coef_addr] <= bus.i_coef_data[2*W-1:W];
                r_tab_b[~r_act][bus.i_coef_addr] <= bus.i_coef_data[W-1:0];
            end
            if (bus.i_coef_swap)
                r_act <= ~r_act;
        end
    end
`else
    logic [W-1:0] r_tab_a [NSEG];
    logic [W-1:0] r_tab_b [NSEG];

    // Table writes ignore the stage enable; reads see them from the next edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NSEG; s++) begin
                r_tab_a[s] <= '0;
                r_tab_b[s] <= '0;
            end
        end else if (bus.i_coef_wr) begin
            r_tab_a[bus.i_coef_addr] <= bus.i_coef_data[2*W-1:W];
            r_tab_b[bus.i_coef_addr] <= bus.i_coef_data[W-1:0];
        end
    end
`endif

    // Valid and mode travel alongside the lane data, frozen by i_en=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld1  <= 1'b0;
            r_vld2  <= 1'b0;
            r_vld3  <= 1'b0;
            r_mode1 <= '0;
            r_mode2 <= '0;
        end else if (i_en) begin
            r_vld1  <= bus.i_valid;
            r_mode1 <= bus.i_mode;
            r_vld2  <= r_vld1;
            r_mode2 <= r_mode1;
            r_vld3  <= r_vld2;
        end
    end

    for (genvar gi = 0; gi < Tn; gi++) begin : g_lane
        logic [W-1:0]        w_x, w_a, w_b, w_y;
        logic [SEG_BITS-1:0] w_seg;

        assign w_x   = bus.i_data[gi*W +: W];
        // Offset-binary segment: flipping the sign bit orders segments by value.
        assign w_seg = {~w_x[W-1], w_x[W-2 -: SEG_BITS-1]};
`ifdef NFU3_COEF_DBUF_EN
        assign w_a = r_tab_a[r_act][w_seg];
        assign w_b = r_tab_b[r_act][w_seg];
`else
        assign w_a = r_tab_a[w_seg];
        assign w_b = r_tab_b[w_seg];
`endif

        nfu3_pwl_lane #(
            .BIT_WIDTH (BIT_WIDTH),
            .FRAC_BITS (FRAC_BITS)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (i_en),
            .i_vld2  (r_vld2),
            .i_mode2 (r_mode2),
            .i_x     (w_x),
            .i_a     (w_a),
            .i_b     (w_b),
            .o_y     (w_y)
        );

        assign w_odata[gi*W +: W] = w_y;
    end

    assign bus.o_valid = r_vld3;
    assign bus.o_data  = w_odata;

endmodule
